// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants, write-back source enum and index decode helper.
package rf_pkg;
   localparam int REG_CNT = 32;
   localparam int REG_IDW = 5;
   typedef enum logic {WB_ALU, WB_LD} wb_src_t;
   function automatic logic [REG_CNT-1:0] onehot(input logic en, input logic [REG_IDW-1:0] idx);
      return en ? REG_CNT'(1) << idx : '0;
   endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: write-back request channels, issue notification and register-file write port.
interface rf_wb_arbiter_if import rf_pkg::*; #(parameter int DWIDTH = 32);
   logic alu_valid, alu_ready, ld_valid, ld_ready, issue_valid, we;
   logic [REG_IDW-1:0] alu_rd, ld_rd, issue_rd, rdst_id;
   logic [DWIDTH-1:0] alu_data, ld_data, rdst;
   logic [REG_CNT-1:0] pending;
   modport master(
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
      input alu_ready, ld_ready, we, rdst_id, rdst, pending
   );
   modport slave(
      input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
      output alu_ready, ld_ready, we, rdst_id, rdst, pending
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bitmap; a set and clear of the same index resolves to set, bit 0 never set.
module rf_scoreboard import rf_pkg::*; (
   input  logic               clk,
   input  logic               rst,
   input  logic               set_en_i,
   input  logic [REG_IDW-1:0] set_idx_i,
   input  logic               clr_en_i,
   input  logic [REG_IDW-1:0] clr_idx_i,
   output logic [REG_CNT-1:0] pending_o
);
   logic [REG_CNT-1:0] pending_q, pending_d;
   always_comb begin
      pending_d = (pending_q & ~onehot(clr_en_i, clr_idx_i)) | onehot(set_en_i, set_idx_i);
      pending_d[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else pending_q <= pending_d;
   end
   assign pending_o = pending_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and load write-backs onto the register-file port and tracks pending writes.
// RF_WB_ARB_RR_EN selects round-robin on conflict; otherwise load has fixed priority.
module rf_wb_arbiter import rf_pkg::*; #(parameter int DWIDTH = 32) (
   input logic clk,
   input logic rst,
   rf_wb_arbiter_if.slave bus
);
   wb_src_t win;
   logic hs, we_q, we_d;
   logic [REG_IDW-1:0] sel_rd, rdst_id_q, rdst_id_d;
   logic [DWIDTH-1:0] sel_data, rdst_q, rdst_d;
`ifdef RF_WB_ARB_RR_EN
   wb_src_t last_q;
   logic conflict;
   assign conflict = bus.alu_valid & bus.ld_valid;
   assign win = conflict ? (last_q == WB_ALU ? WB_LD : WB_ALU) : (bus.ld_valid ? WB_LD : WB_ALU);
   always_ff @(posedge clk) begin
      if (rst) last_q <= WB_ALU;
      else if (conflict) last_q <= win;
   end
`else
   assign win = bus.ld_valid ? WB_LD : WB_ALU;
`endif
   assign bus.ld_ready  = bus.ld_valid & (win == WB_LD);
   assign bus.alu_ready = bus.alu_valid & (win == WB_ALU);
   assign hs = bus.alu_ready | bus.ld_ready;
   assign sel_rd = win == WB_LD ? bus.ld_rd : bus.alu_rd;
   assign sel_data = win == WB_LD ? bus.ld_data : bus.alu_data;
   // rd=0 requests are consumed but never raise we
   assign we_d = hs & (sel_rd != '0);
   assign rdst_id_d = hs ? sel_rd : rdst_id_q;
   assign rdst_d = hs ? sel_data : rdst_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q <= 1'b0;
         rdst_id_q <= '0;
         rdst_q <= '0;
      end else begin
         we_q <= we_d;
         rdst_id_q <= rdst_id_d;
         rdst_q <= rdst_d;
      end
   end
   assign bus.we = we_q;
   assign bus.rdst_id = rdst_id_q;
   assign bus.rdst = rdst_q;
   rf_scoreboard u_sb (
      .clk(clk),
      .rst(rst),
      .set_en_i(bus.issue_valid),
      .set_idx_i(bus.issue_rd),
      .clr_en_i(we_q),
      .clr_idx_i(rdst_id_q),
      .pending_o(bus.pending)
   );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table-driven directed checks of grant, write port and scoreboard behaviour.
module tb_rf_wb_arbiter;
`ifdef RF_WB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] ad;
      logic lv; logic [4:0] lrd; logic [31:0] ld;
      logic iv; logic [4:0] ird;
      logic ear, elr, ewe; logic [4:0] eid; logic [31:0] ed, ep;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1;
   int n_chk = 0, n_fail = 0;
   vec_t tbl[22];
   rf_wb_arbiter_if #(.DWIDTH(32)) bus();
   rf_wb_arbiter #(.DWIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad, logic lv, logic [4:0] lrd,
                               logic [31:0] ld, logic iv, logic [4:0] ird, logic ear, logic elr,
                               logic ewe, logic [4:0] eid, logic [31:0] ed, logic [31:0] ep);
      vec_t v;
      v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld; v.iv = iv; v.ird = ird;
      v.ear = ear; v.elr = elr; v.ewe = ewe; v.eid = eid; v.ed = ed; v.ep = ep;
      return v;
   endfunction
   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask
   task automatic drive(input vec_t v);
      bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.ad;
      bus.ld_valid = v.lv; bus.ld_rd = v.lrd; bus.ld_data = v.ld;
      bus.issue_valid = v.iv; bus.issue_rd = v.ird;
   endtask
   task automatic chk_out(input int row, input logic ewe, input logic [4:0] eid, input logic [31:0] ed,
                          input logic [31:0] ep);
      chk("we", row, 32'(bus.we), 32'(ewe));
      chk("rdst_id", row, 32'(bus.rdst_id), 32'(eid));
      chk("rdst", row, bus.rdst, ed);
      chk("pending", row, bus.pending, ep);
   endtask
   initial begin
      tbl[0]  = mk(1, 5, 32'h1234, 0, 0, 0, 0, 0, 1, 0, 1, 5, 32'h1234, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h1234, 0);
      tbl[2]  = mk(1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 1, 1, 2, 32'hB, 0);
      tbl[3]  = mk(1, 1, 32'hA, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'hA, 0);
      tbl[4]  = mk(1, 3, 32'hC, 1, 4, 32'hD, 0, 0, RR, !RR, 1, RR ? 5'd3 : 5'd4, RR ? 32'hC : 32'hD, 0);
      tbl[5]  = mk(!RR, 3, 32'hC, RR, 4, 32'hD, 0, 0, !RR, RR, 1, RR ? 5'd4 : 5'd3, RR ? 32'hD : 32'hC, 0);
      tbl[6]  = mk(1, 5, 32'hE, 1, 6, 32'hF, 0, 0, 0, 1, 1, 6, 32'hF, 0);
      tbl[7]  = mk(1, 5, 32'hE, 0, 0, 0, 0, 0, 1, 0, 1, 5, 32'hE, 0);
      tbl[8]  = mk(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 32'hFFFF, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'hFFFF, 32'h80);
      tbl[10] = mk(1, 7, 32'h77, 0, 0, 0, 0, 0, 1, 0, 1, 7, 32'h77, 32'h80);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 7, 32'h77, 32'h80);
      tbl[13] = mk(1, 7, 32'h99, 0, 0, 0, 0, 0, 1, 0, 1, 7, 32'h99, 32'h80);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 7, 32'h99, 32'h80);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h99, 32'h80);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7, 32'h99, 32'h80);
      for (int k = 1; k <= 4; k++)
         tbl[16+k] = mk(1, 5'(k), 32'h100 + 32'(k), 0, 0, 0, 0, 0, 1, 0, 1, 5'(k), 32'h100 + 32'(k), 32'h80);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h104, 32'h80);
      drive(mk(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk_out(-1, 0, 0, 0, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.alu_valid = 1'b0;
      @(posedge clk); #1;
      chk_out(-2, 0, 0, 0, 0);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk("alu_ready", i, 32'(bus.alu_ready), 32'(tbl[i].ear));
         chk("ld_ready", i, 32'(bus.ld_ready), 32'(tbl[i].elr));
         @(posedge clk); #1;
         chk_out(i, tbl[i].ewe, tbl[i].eid, tbl[i].ed, tbl[i].ep);
      end
      @(negedge clk);
      drive(mk(1, 9, 32'h55, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      @(posedge clk); #1;
      chk_out(100, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      chk_out(101, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
